// File: rtl/ysyx_24100029_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_24100029_ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        ADDR = 2'd0,
        DATA = 2'd1,
        OUT  = 2'd2,
        DROP = 2'd3
    } ifu_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: one outstanding AXI-lite style read at a time,
// redirects either retarget the next fetch or drain the in-flight response.
module ysyx_24100029_ifu
    import ysyx_24100029_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        master_valid,
    input  logic        master_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_fault
);

    ifu_state_e  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic        ar_req;
    logic [31:0] redir_pc;

    assign redir_pc = align_word(redirect_pc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ADDR;
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= 32'h0;
            inst_q     <= 32'h0;
            pc_q       <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        ar_req       = 1'b0;
        r_ready      = 1'b0;
        master_valid = 1'b0;
        case (state_q)
            ADDR: begin
                ar_req = 1'b1;
                // The address must not move mid-request, so a redirect here only arms DROP.
                if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redir_pc;
                end
                if (ar_ready) begin
                    state_d = (pend_q || redirect_valid) ? DROP : DATA;
                end
            end
            DATA: begin
                r_ready = 1'b1;
                if (redirect_valid) begin
                    if (r_valid) begin
                        state_d    = ADDR;
                        fetch_pc_d = redir_pc;
                    end else begin
                        state_d   = DROP;
                        pend_d    = 1'b1;
                        pend_pc_d = redir_pc;
                    end
                end else if (r_valid) begin
                    state_d = OUT;
                    inst_d  = r_data;
                    pc_d    = fetch_pc_q;
                    fault_d = (r_resp != 2'b00);
                end
            end
            OUT: begin
                master_valid = 1'b1;
                if (redirect_valid) begin
                    state_d    = ADDR;
                    fetch_pc_d = redir_pc;
                end else if (master_ready) begin
                    state_d    = ADDR;
                    fetch_pc_d = pc_q + PC_INC;
                end
            end
            DROP: begin
                r_ready = 1'b1;
                if (redirect_valid) begin
                    pend_pc_d = redir_pc;
                end
                if (r_valid) begin
                    state_d    = ADDR;
                    pend_d     = 1'b0;
                    fetch_pc_d = redirect_valid ? redir_pc : pend_pc_q;
                end
            end
            default: state_d = ADDR;
        endcase
    end

    // Gated by reset so no request is visible while reset is held.
    assign ar_valid   = ar_req & reset;
    assign ar_addr    = fetch_pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_fault = fault_q;

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Directed bench for the fetch unit with a small latency-configurable memory responder.
module tb_ysyx_24100029_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        master_valid;
    logic        master_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;

    int          checks = 0;
    int          failures = 0;
    int          lat;
    logic [31:0] mem_word;
    logic [31:0] fault_addr;
    logic [31:0] ar_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] inst_log[$];
    logic        fault_log[$];
    logic [8:0]  mv_bits;

    always #5 clock = ~clock;

    ysyx_24100029_ifu dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .master_valid(master_valid), .master_ready(master_ready),
        .inst(inst), .pc(pc), .inst_fault(inst_fault)
    );

    // Memory responder and transaction logger, both evaluated mid-cycle.
    initial begin : mem_model
        logic        hs_prev, ar_prev, pend;
        int          cnt;
        logic [31:0] addr_prev, addr_cur;
        hs_prev = 0; ar_prev = 0; pend = 0; cnt = 0; addr_prev = 0; addr_cur = 0;
        r_valid = 0; r_data = 0; r_resp = 0; mv_bits = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                r_valid = 0; hs_prev = 0; ar_prev = 0; pend = 0;
            end else begin
                if (hs_prev) r_valid = 0;
                if (ar_prev) begin pend = 1; cnt = lat; addr_cur = addr_prev; end
                if (pend) begin
                    if (cnt == 0) begin
                        r_valid = 1; r_data = mem_word;
                        r_resp = (addr_cur == fault_addr) ? 2'b10 : 2'b00;
                        pend = 0;
                    end else cnt--;
                end
                hs_prev   = r_valid && r_ready;
                ar_prev   = ar_valid && ar_ready;
                addr_prev = ar_addr;
                if (ar_prev) ar_log.push_back(ar_addr);
                if (master_valid && master_ready) begin
                    pc_log.push_back(pc); inst_log.push_back(inst); fault_log.push_back(inst_fault);
                end
                mv_bits = {mv_bits[7:0], master_valid};
            end
        end
    end

    task automatic clear_logs;
        ar_log.delete(); pc_log.delete(); inst_log.delete(); fault_log.delete(); mv_bits = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic do_reset;
        @(posedge clock); #2;
        reset = 0; redirect_valid = 0; redirect_pc = 0; master_ready = 1; ar_ready = 1;
        lat = 0; mem_word = 32'h0000_0013; fault_addr = 32'h0000_0001;
        @(posedge clock); #2;
        reset = 1;
        clear_logs();
    endtask

    task automatic test_reset;
        reset = 0; redirect_valid = 0; redirect_pc = 0; master_ready = 1; ar_ready = 1;
        lat = 0; mem_word = 32'h0000_0013; fault_addr = 32'h0000_0001;
        #12;
        checks++;
        if ({ar_valid, r_ready, master_valid, inst_fault} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {ar_valid, r_ready, master_valid, inst_fault});
        end
        checks++;
        if ({inst, pc} !== 64'h0) begin
            failures++; $display("FAIL reset_regs inst=%h pc=%h exp=0", inst, pc);
        end
        @(posedge clock); #2;
        reset = 1;
        #1;
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 32'h3000_0000) begin
            failures++; $display("FAIL reset_release ar_valid=%b ar_addr=%h exp=1/30000000", ar_valid, ar_addr);
        end
    endtask

    task automatic test_stream;
        do_reset();
        repeat (9) @(negedge clock);
        #1;
        checks++;
        if (mv_bits !== 9'b001001001) begin
            failures++; $display("FAIL stream_mv_pattern got=%b exp=001001001", mv_bits);
        end
        checks++;
        if (ar_log.size() != 3 || ar_log[0] !== 32'h3000_0000 || ar_log[1] !== 32'h3000_0004 || ar_log[2] !== 32'h3000_0008) begin
            failures++; $display("FAIL stream_ar_addrs n=%0d exp 30000000,30000004,30000008", ar_log.size());
        end
        checks++;
        if (pc_log.size() != 3 || pc_log[2] !== 32'h3000_0008 || inst_log[2] !== 32'h0000_0013) begin
            failures++; $display("FAIL stream_delivery n=%0d exp=3 last pc 30000008 inst 13", pc_log.size());
        end
    endtask

    task automatic test_stall;
        do_reset();
        master_ready = 0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            checks++;
            if ({master_valid, ar_valid, pc, inst} !== {1'b1, 1'b0, 32'h3000_0000, 32'h0000_0013}) begin
                failures++; $display("FAIL stall_hold_%0d mv=%b arv=%b pc=%h inst=%h exp 1/0/30000000/13", i, master_valid, ar_valid, pc, inst);
            end
        end
        @(posedge clock); #2;
        master_ready = 1;
        step(1);
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 32'h3000_0004 || pc_log.size() != 1) begin
            failures++; $display("FAIL stall_release arv=%b ar_addr=%h n=%0d exp 1/30000004/1", ar_valid, ar_addr, pc_log.size());
        end
    endtask

    task automatic test_redirect_data;
        do_reset();
        lat = 4;
        step(2);
        redirect_valid = 1; redirect_pc = 32'h8000_0010; lat = 0;
        step(1);
        redirect_valid = 0;
        step(7);
        checks++;
        if (ar_log.size() < 2 || ar_log[1] !== 32'h8000_0010) begin
            failures++; $display("FAIL redir_data_addr n=%0d got=%h exp=80000010", ar_log.size(), ar_log.size() > 1 ? ar_log[1] : 32'h0);
        end
        checks++;
        if (pc_log.size() != 1 || pc_log[0] !== 32'h8000_0010) begin
            failures++; $display("FAIL redir_data_drop n=%0d exp one delivery at 80000010", pc_log.size());
        end
    endtask

    task automatic test_redirect_handshake;
        do_reset();
        step(5);
        redirect_valid = 1; redirect_pc = 32'h8000_0020;
        step(1);
        redirect_valid = 0;
        step(5);
        checks++;
        if (pc_log.size() != 3 || pc_log[1] !== 32'h3000_0004 || pc_log[2] !== 32'h8000_0020) begin
            failures++; $display("FAIL redir_hs_delivery n=%0d exp 3 with 30000004 then 80000020", pc_log.size());
        end
        checks++;
        if (ar_log.size() < 3 || ar_log[2] !== 32'h8000_0020) begin
            failures++; $display("FAIL redir_hs_addr n=%0d exp third ar_addr 80000020", ar_log.size());
        end
    endtask

    task automatic test_redirect_out;
        do_reset();
        master_ready = 0;
        step(3);
        redirect_valid = 1; redirect_pc = 32'h8000_0033;
        step(1);
        redirect_valid = 0;
        checks++;
        if ({master_valid, ar_valid} !== 2'b01 || ar_addr !== 32'h8000_0030) begin
            failures++; $display("FAIL redir_out mv=%b arv=%b ar_addr=%h exp 0/1/80000030", master_valid, ar_valid, ar_addr);
        end
        master_ready = 1;
        step(4);
        checks++;
        if (pc_log.size() != 1 || pc_log[0] !== 32'h8000_0030) begin
            failures++; $display("FAIL redir_out_discard n=%0d exp one delivery at 80000030", pc_log.size());
        end
    endtask

    task automatic test_addr_hold;
        do_reset();
        ar_ready = 0;
        step(1);
        redirect_valid = 1; redirect_pc = 32'h9000_0000;
        step(1);
        redirect_pc = 32'h9000_0104;
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 32'h3000_0000) begin
            failures++; $display("FAIL addr_hold arv=%b ar_addr=%h exp 1/30000000", ar_valid, ar_addr);
        end
        step(1);
        redirect_valid = 0; ar_ready = 1;
        checks++;
        if (ar_addr !== 32'h3000_0000) begin
            failures++; $display("FAIL addr_hold2 ar_addr=%h exp 30000000", ar_addr);
        end
        step(2);
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 32'h9000_0104) begin
            failures++; $display("FAIL latest_redirect arv=%b ar_addr=%h exp 1/90000104", ar_valid, ar_addr);
        end
        step(4);
        checks++;
        if (pc_log.size() != 1 || pc_log[0] !== 32'h9000_0104) begin
            failures++; $display("FAIL addr_hold_drop n=%0d exp one delivery at 90000104", pc_log.size());
        end
    endtask

    task automatic test_redirect_rvalid;
        do_reset();
        step(1);
        redirect_valid = 1; redirect_pc = 32'h8000_0040;
        step(1);
        redirect_valid = 0;
        checks++;
        if ({master_valid, ar_valid} !== 2'b01 || ar_addr !== 32'h8000_0040) begin
            failures++; $display("FAIL redir_rvalid mv=%b arv=%b ar_addr=%h exp 0/1/80000040", master_valid, ar_valid, ar_addr);
        end
    endtask

    task automatic test_fault;
        do_reset();
        fault_addr = 32'h3000_0008; mem_word = 32'hDEAD_BEEF;
        step(12);
        checks++;
        if (pc_log.size() < 4 || pc_log[2] !== 32'h3000_0008 || fault_log[2] !== 1'b1 || inst_log[2] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL fault_delivery n=%0d exp pc 30000008 fault 1 inst deadbeef", pc_log.size());
        end
        checks++;
        if (pc_log.size() < 4 || fault_log[0] !== 1'b0 || fault_log[3] !== 1'b0 || pc_log[3] !== 32'h3000_000C) begin
            failures++; $display("FAIL fault_neighbours n=%0d exp fault 0 around, next pc 3000000c", pc_log.size());
        end
    endtask

    task automatic test_wrap;
        do_reset();
        step(2);
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 0;
        step(3);
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_0000) begin
            failures++; $display("FAIL pc_wrap arv=%b ar_addr=%h exp 1/00000000", ar_valid, ar_addr);
        end
        checks++;
        if (pc_log.size() != 2 || pc_log[1] !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL pc_wrap_delivery n=%0d exp second delivery fffffffc", pc_log.size());
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        step(4);
        checks++;
        if (r_ready !== 1'b1 || pc !== 32'h3000_0000 || inst !== 32'h0000_0013) begin
            failures++; $display("FAIL pre_reset rr=%b pc=%h inst=%h exp 1/30000000/13", r_ready, pc, inst);
        end
        reset = 0;
        #1;
        checks++;
        if ({ar_valid, r_ready, master_valid, inst_fault, pc, inst} !== 68'h0) begin
            failures++; $display("FAIL async_reset arv=%b rr=%b mv=%b f=%b pc=%h inst=%h exp all 0", ar_valid, r_ready, master_valid, inst_fault, pc, inst);
        end
        @(posedge clock); #2;
        reset = 1;
        clear_logs();
        #1;
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 32'h3000_0000) begin
            failures++; $display("FAIL reset_restart arv=%b ar_addr=%h exp 1/30000000", ar_valid, ar_addr);
        end
        step(3);
        checks++;
        if (pc_log.size() != 1 || pc_log[0] !== 32'h3000_0000) begin
            failures++; $display("FAIL reset_restart_delivery n=%0d exp one at 30000000", pc_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_data();
        test_redirect_handshake();
        test_redirect_out();
        test_addr_hold();
        test_redirect_rvalid();
        test_fault();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_24100029_ifu.md
YSYX_24100029_IFU -- requirements
Module: ysyx_24100029_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h3000_0000, the first fetch address after reset.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low: asserted when 0.
REQ-004 SHALL have port redirect_valid  input  1  one-cycle request from branch/jump/trap/fence_i resolution to refetch.
REQ-005 SHALL have port redirect_pc  input  32  target address for redirect.
REQ-006 SHALL have port ar_valid  output  1  fetch address valid.
REQ-007 SHALL have port ar_ready  input  1  memory accepts address.
REQ-008 SHALL have port ar_addr  output  32  fetch address, word aligned.
REQ-009 SHALL have port r_valid  input  1  read data valid.
REQ-010 SHALL have port r_ready  output  1  IFU accepts read data.
REQ-011 SHALL have port r_data  input  32  instruction word.
REQ-012 SHALL have port r_resp  input  2  response code; nonzero is an access fault.
REQ-013 SHALL have port master_valid  output  1  inst/pc valid toward the decode stage (its slave_valid).
REQ-014 SHALL have port master_ready  input  1  decode stage ready (its slave_ready).
REQ-015 SHALL have port inst  output  32  fetched instruction.
REQ-016 SHALL have port pc  output  32  address of inst.
REQ-017 SHALL have port inst_fault  output  1  inst came from a nonzero r_resp.

Function
REQ-018 SHALL implement FSM states ADDR, DATA, OUT, DROP.
REQ-019 ADDR: ar_valid=1, ar_addr=fetch_pc; on ar_valid&ar_ready go to DATA, or to DROP if a redirect is pending.
REQ-020 ar_addr SHALL stay constant while ar_valid=1 and ar_ready=0, including when a redirect arrives.
REQ-021 DATA: r_ready=1; on r_valid, capture r_data into inst, fetch_pc into pc, (r_resp!=0) into inst_fault, and go to OUT.
REQ-022 OUT: master_valid=1; inst, pc and inst_fault SHALL hold stable until master_valid&master_ready.
REQ-023 On the OUT handshake, fetch_pc SHALL become pc+4 (modulo 2^32, wrap at 32'hFFFF_FFFC to 0) and the FSM SHALL go to ADDR.
REQ-024 Steady-state throughput SHALL be one instruction per 3 cycles with zero-wait memory and master_ready=1.
REQ-025 A redirect in OUT SHALL deassert master_valid next cycle, set fetch_pc=redirect_pc, and go to ADDR; the held instruction is discarded.
REQ-026 A redirect in the same cycle as the OUT handshake SHALL count that instruction as delivered, and fetch_pc SHALL take redirect_pc, not pc+4.
REQ-027 A redirect in ADDR (before the address handshake) or in DATA SHALL be latched as pending.
REQ-028 With a redirect pending, the in-flight response SHALL be consumed in DROP (r_ready=1) and discarded, never presented on master_valid.
REQ-029 When DROP completes, the FSM SHALL go to ADDR with fetch_pc=redirect_pc.
REQ-030 If several redirects arrive before the pending one is serviced, the latest redirect_pc SHALL win.
REQ-031 redirect_pc[1:0] SHALL be forced to 2'b00.
REQ-032 If redirect and r_valid coincide in DATA, the response SHALL be discarded and the FSM SHALL go straight to ADDR with the new pc.
REQ-033 A fault response SHALL still be delivered with inst_fault=1 and inst=r_data; no retry.

Reset
REQ-034 While reset=0: state=ADDR, fetch_pc=RESET_PC, pending redirect cleared, master_valid=0, inst=0, pc=0, inst_fault=0, r_ready=0.
REQ-035 ar_valid SHALL be 0 while reset=0 and assert in the first cycle after release with ar_addr=RESET_PC.
REQ-036 Reset asserted mid-transaction SHALL abandon it immediately; a late r_valid after release SHALL be ignored, since the FSM is in ADDR with r_ready=0.

Structure
REQ-037 The state enum ifu_state_e SHALL live in the shared struct package; RESET_PC default and the PC increment constant (4) SHALL live in the shared para defines.
REQ-038 There SHALL be no sub-module; the FSM, fetch_pc register, pending-redirect register and output register SHALL be in one module.

Verification
REQ-039 Zero-wait memory returning r_data=32'h0000_0013, master_ready=1 -> ar_addr sequence 3000_0000, 3000_0004, 3000_0008, with master_valid pulsing every 3rd cycle.
REQ-040 master_ready=0 for 5 cycles in OUT -> inst/pc stable, no new ar_valid; on ready=1, the next ar_addr is pc+4.
REQ-041 Redirect to 32'h8000_0010 while in DATA with r_valid delayed 4 cycles -> old data never presented; next ar_addr=8000_0010.
REQ-042 Redirect to 32'h8000_0020 coincident with the OUT handshake at pc 3000_0004 -> that instruction delivered; next ar_addr=8000_0020.
REQ-043 r_resp=2'b10 on the fetch at 3000_0008 -> master_valid with inst_fault=1 and pc=3000_0008; the following fetch has inst_fault=0.
REQ-044 reset pulsed low while in DATA -> all outputs are at reset values asynchronously; the first ar_addr after release is 3000_0000.
